// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_pkg
// Purpose  : Shared widths, queue entry layout and PC limit helper for the
//            instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // Default instruction ROM size in bytes.
    localparam int unsigned ROM_BYTES = 100;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // True when a word fetch at pc would run past the end of the ROM.
    // One extra bit keeps pc+3 from wrapping near the top of the address space.
    function automatic logic pc_at_limit(input logic [ADDR_W-1:0] pc,
                                         input logic [ADDR_W-1:0] limit);
        return ({1'b0, pc} + (ADDR_W+1)'(3)) >= {1'b0, limit};
    endfunction

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_if
// Purpose  : ROM read port, issue handshake and redirect signals of the
//            instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                rom_nrd;
    logic [ADDR_W-1:0]   rom_addr;
    logic [INST_W-1:0]   rom_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_W-1:0]   inst;
    logic [ADDR_W-1:0]   inst_pc;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                fetch_done;
    logic [CNT_W-1:0]    q_count;

    // Fetch unit side.
    modport master (
        output rom_nrd,
        output rom_addr,
        input  rom_data,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_done,
        output q_count
    );

    // ROM / issue stage / branch unit side.
    modport slave (
        input  rom_nrd,
        input  rom_addr,
        output rom_data,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc,
        input  fetch_done,
        input  q_count
    );

endinterface : inst_fetch_queue_if
`default_nettype wire

// File: rtl/inst_fetch_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_sync_fifo
// Purpose  : Parameterised synchronous FIFO with occupancy count and a
//            synchronous flush; push into a full FIFO is accepted when a pop
//            happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_clear,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // When full, the slot being popped is the one the push overwrites.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy tracking decides what is visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule : inst_fetch_queue_sync_fifo
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Instruction fetch initiator: reads the instruction ROM one word
//            per cycle into a small queue and hands words to the issue stage
//            over valid/ready; a redirect flushes the queue and reloads PC.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_LIMIT = ROM_BYTES
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_fetch_queue_if.master    bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);

    logic [ADDR_W-1:0] r_pc;
    logic              r_fetch_done;

    logic              w_fetch_en;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_next_pc;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;

    assign bus.inst_valid = !w_empty && !bus.redirect_valid;
    assign w_pop          = bus.inst_valid && bus.inst_ready;

    // A full queue can still fetch when its head leaves in the same cycle.
    assign w_fetch_en = !rst && !bus.redirect_valid && !r_fetch_done
                        && (!w_full || w_pop);

    assign w_next_pc  = r_pc + PC_STEP;
    assign w_wr_entry = '{inst: bus.rom_data, pc: r_pc};

    assign bus.rom_nrd    = !w_fetch_en;
    assign bus.rom_addr   = r_pc;
    assign bus.fetch_done = r_fetch_done;
    assign bus.q_count    = w_count;
    assign bus.inst       = w_empty ? '0 : w_head.inst;
    assign bus.inst_pc    = w_empty ? '0 : w_head.pc;

    inst_fetch_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.redirect_valid),
        .i_push  (w_fetch_en),
        .i_pop   (w_pop),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // fetch_done looks one step ahead so no fetch is issued past the ROM end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_fetch_done <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc         <= bus.redirect_pc;
            r_fetch_done <= pc_at_limit(bus.redirect_pc, LIMIT);
        end else if (w_fetch_en) begin
            r_pc         <= w_next_pc;
            r_fetch_done <= pc_at_limit(w_next_pc, LIMIT);
        end
    end

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue with a queue-based
//            reference model of PC, occupancy and expected instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 100;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ent_t        sbq[$];
    logic [31:0] m_pc;
    logic        m_done;
    bit          m_known = 0;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) bus();

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .PC_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h1111_1111;
    endfunction

    // Combinational ROM: always presents the word at the current address.
    assign bus.rom_data = rom_word(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check against the model mid-cycle, then advance the model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic r);
        logic exp_valid, exp_pop, exp_fetch;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        rst                = r;
        @(negedge clk);
        exp_valid = (sbq.size() != 0) && !rv;
        exp_pop   = exp_valid && rdy;
        exp_fetch = !r && !rv && !m_done && ((sbq.size() < DEPTH) || exp_pop);
        if (m_known) begin
            chk("rom_nrd",    bus.rom_nrd,    !exp_fetch);
            chk("rom_addr",   bus.rom_addr,   m_pc);
            chk("inst_valid", bus.inst_valid, exp_valid);
            chk("q_count",    bus.q_count,    sbq.size());
            chk("fetch_done", bus.fetch_done, m_done);
            if (exp_valid) begin
                chk("inst",    bus.inst,    sbq[0].inst);
                chk("inst_pc", bus.inst_pc, sbq[0].pc);
            end
        end
        @(posedge clk);
        if (r) begin
            sbq.delete();
            m_pc    = 32'h0;
            m_done  = 1'b0;
            m_known = 1;
        end else if (rv) begin
            sbq.delete();
            m_pc   = rpc;
            m_done = ({1'b0, rpc} + 33'd3) >= 33'(LIMIT);
        end else begin
            if (exp_pop) void'(sbq.pop_front());
            if (exp_fetch) begin
                sbq.push_back('{inst: rom_word(m_pc), pc: m_pc});
                m_pc   = m_pc + 32'd4;
                m_done = ({1'b0, m_pc} + 33'd3) >= 33'(LIMIT);
            end
        end
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        rst                = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("reset_q_count",    bus.q_count,    0);
        chk("reset_rom_addr",   bus.rom_addr,   32'h0);
        chk("reset_fetch_done", bus.fetch_done, 1'b0);

        // Streaming at one instruction per cycle
        run(6, 1'b1);
        chk("stream_inst_pc",  bus.inst_pc,  32'd20);
        chk("stream_rom_addr", bus.rom_addr, 32'd24);
        chk("stream_q_count",  bus.q_count,  1);

        // Backpressure fills the queue, then pop and fetch in the same cycle
        step(1'b0, 1'b0, 32'h0, 1'b1);
        run(6, 1'b0);
        chk("full_q_count",  bus.q_count,  4);
        chk("full_rom_addr", bus.rom_addr, 32'd16);
        run(1, 1'b1);
        chk("fullpop_q_count",  bus.q_count,  4);
        chk("fullpop_rom_addr", bus.rom_addr, 32'd20);
        chk("fullpop_inst_pc",  bus.inst_pc,  32'd4);

        // Redirect with three entries queued
        step(1'b0, 1'b0, 32'h0, 1'b1);
        run(3, 1'b0);
        chk("preredir_q_count", bus.q_count, 3);
        step(1'b0, 1'b1, 32'h20, 1'b0);
        chk("redir_rom_addr", bus.rom_addr, 32'h20);
        chk("redir_q_count",  bus.q_count,  0);
        run(1, 1'b0);
        chk("redir_inst_pc", bus.inst_pc, 32'h20);
        chk("redir_inst",    bus.inst,    rom_word(32'h20));

        // End of ROM: last fetch at 96, then drain
        step(1'b1, 1'b1, 32'd80, 1'b0);
        run(8, 1'b1);
        chk("eor_fetch_done", bus.fetch_done, 1'b1);
        chk("eor_rom_addr",   bus.rom_addr,   32'd100);
        chk("eor_q_count",    bus.q_count,    0);
        step(1'b1, 1'b1, 32'h0, 1'b0);
        chk("eor_clear_done", bus.fetch_done, 1'b0);
        chk("eor_clear_addr", bus.rom_addr,   32'h0);

        // Redirect to 96 allows one fetch; redirect to 98 allows none
        step(1'b0, 1'b1, 32'd96, 1'b0);
        chk("r96_done_before", bus.fetch_done, 1'b0);
        run(1, 1'b0);
        chk("r96_done_after", bus.fetch_done, 1'b1);
        chk("r96_q_count",    bus.q_count,    1);
        step(1'b0, 1'b1, 32'd98, 1'b0);
        chk("r98_done", bus.fetch_done, 1'b1);
        run(2, 1'b1);
        chk("r98_q_count",  bus.q_count,  0);
        chk("r98_rom_addr", bus.rom_addr, 32'd98);

        // Reset mid-operation with two entries queued and PC at 40
        step(1'b0, 1'b1, 32'd32, 1'b0);
        run(2, 1'b0);
        chk("mid_q_count",  bus.q_count,  2);
        chk("mid_rom_addr", bus.rom_addr, 32'd40);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rstmid_q_count",  bus.q_count,  0);
        chk("rstmid_rom_addr", bus.rom_addr, 32'h0);
        run(1, 1'b0);
        chk("rstmid_inst_pc", bus.inst_pc, 32'h0);
        chk("rstmid_inst",    bus.inst,    32'h1111_1111);

        // Randomised ready, redirects and occasional reset against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 32'($urandom_range(0, 26)) << 2,
                 ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch initiator for the byte-addressed instruction ROM.
- Each cycle with queue space, it drives an active-low read strobe and a byte address (PC). It captures the combinational 32-bit big-endian word the ROM returns that cycle into a small FIFO, then advances PC by 4.
- Presents queued instructions to the Tomasulo issue stage over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and reloads PC.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, minimum 2.
- RESET_PC, 32'h0, PC value after reset.
- PC_LIMIT, 100, ROM size in bytes; fetch allowed only while PC + 3 < PC_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- rom_nrd  out  1  ROM read strobe, active low.
- rom_addr  out  32  ROM byte address; always equals PC.
- rom_data  in  32  ROM word; valid in the same cycle rom_nrd=0; high-Z otherwise.
- inst_valid  out  1  queue head holds an instruction.
- inst_ready  in  1  issue stage accepts the head this cycle.
- inst  out  32  head instruction word.
- inst_pc  out  32  byte address of the head instruction.
- redirect_valid  in  1  flush the queue and load PC from redirect_pc.
- redirect_pc  in  32  new PC; must be word-aligned.
- fetch_done  out  1  PC has reached PC_LIMIT; no further fetches.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst=1 at posedge), regardless of state:
  - PC=RESET_PC; queue empty; pointers=0; q_count=0.
  - inst_valid=0, rom_nrd=1, fetch_done=0.
  - inst/inst_pc: don't-care, but driven to 0.
  - Reset mid-fetch discards the word being fetched that cycle.
- fetch_en (combinational) = !rst && !redirect_valid && !fetch_done && (q_count<DEPTH || pop).
  - pop = inst_valid && inst_ready.
  - rom_nrd = !fetch_en.
  - rom_addr = PC at all times.
- Push: when fetch_en, at posedge:
  - write {rom_data, PC} into entry at wr_ptr;
  - wr_ptr += 1 (mod DEPTH);
  - PC += 4 (32-bit wrap, unreachable in practice).
- Fetch latency: ROM word fetched in cycle N is visible at inst in cycle N+1 when the queue was empty. There is no bypass from rom_data to inst.
- Pop: when pop, rd_ptr += 1 (mod DEPTH).
- Occupancy update:
  - push and pop together: q_count unchanged; this is allowed when full, giving sustained 1 instruction/cycle.
  - push only: +1.
  - pop only: −1.
- Full: no fetch unless popping in the same cycle; rom_nrd=1.
- Empty: inst_valid=0; inst_ready is ignored.
- fetch_done is registered; it is set at the edge where the next PC would satisfy PC+3 >= PC_LIMIT.
  - Draining continues normally after fetch_done.
  - fetch_done is cleared only by reset or redirect.
- Redirect (redirect_valid=1 at posedge), highest priority after reset:
  - queue emptied; q_count=0; pointers=0;
  - PC=redirect_pc;
  - fetch_done recomputed as (redirect_pc+3 >= PC_LIMIT).
- During a redirect cycle:
  - inst_valid is forced 0, so no pop can occur;
  - rom_nrd=1, so no push occurs.
  - The fetch from redirect_pc happens in the next cycle.
- inst_valid = (q_count != 0) && !redirect_valid.
- inst and inst_pc come from entry rd_ptr and hold stable while inst_valid=1 and inst_ready=0.
- Byte order: the instruction word is rom_data as delivered; the ROM presents addr as bits[31:24]. No reordering in this block.
- Misaligned redirect_pc is not checked; behaviour follows PC arithmetic.
- States: FETCHING, STALLED_FULL and DONE are derived from q_count and fetch_done. There is no explicit FSM register beyond fetch_done.

Decomposition:
- Shared package/header holds:
  - INST_W=32, ADDR_W=32, PC_STEP=4;
  - ROM_BYTES=100 (default for PC_LIMIT);
  - entry packing {inst, pc}.
- One natural sub-module: sync_fifo, a parameterised width/depth FIFO with push, pop, full, empty and count. It is instantiated with width 64.
- PC and fetch_done logic stay in the top.

Test Plan:
- Reset then run, inst_ready=1, ROM words 0x11111111, 0x22222222, … at 0, 4, …:
  - rom_nrd=0 from cycle 1;
  - inst=0x11111111/inst_pc=0 one cycle later;
  - then one instruction per cycle at pc 4, 8, ….
- Backpressure with inst_ready=0:
  - 4 fetches (pc 0–12), then q_count=4 and rom_nrd=1 with rom_addr=16 held.
  - Raise inst_ready: pop and fetch of pc 16 occur in the same cycle; q_count stays 4.
- Redirect with queue holding 3 entries, redirect_valid=1, redirect_pc=0x20:
  - that cycle inst_valid=0 and rom_nrd=1;
  - next cycle rom_addr=0x20, q_count=0;
  - following cycle inst_pc=0x20.
- End of ROM, PC_LIMIT=100, inst_ready=1:
  - last fetch at pc 96; fetch_done=1 thereafter; rom_nrd stays 1;
  - queue drains to inst_valid=0;
  - redirect to 0 clears fetch_done.
- Redirect to 96 with PC_LIMIT=100: one fetch at 96, then fetch_done=1. Redirect to 98: fetch_done=1 immediately, no fetch.
- Reset mid-operation (q_count=2, PC=40):
  - next cycle q_count=0, inst_valid=0, rom_nrd=1, rom_addr=RESET_PC;
  - rom_data captured during the reset cycle never appears at inst.
